nibble_serial_addsub_ctrl: RTL and testbench

Sequencer that performs a W-bit add or subtract by time-multiplexing one 4-bit add/sub nibble slice, least-significant nibble first, carrying between nibbles in a register. It gives the team a wide add/sub at the cost of a single 4-bit ripple slice. It sits between a requester (start/op/operands) and a consumer that waits on done. Its handshake is start/busy/done.

---
 rtl/nibble_addsub_pkg.sv | 13 +
 rtl/addsub_nibble.sv | 29 ++
 rtl/nibble_serial_addsub_ctrl.sv | 91 +++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_addsub_pkg.sv
// Shared encodings for the nibble-serial add/sub sequencer and its 4-bit slice.
package nibble_addsub_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_nibble.sv
// Combinational 4-bit ripple add/sub slice: s = a + (b ^ {4{sub}}) + cin.
// Exposes the carry into bit 3 so the caller can derive signed overflow.
module addsub_nibble
  import nibble_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                c4
);

  logic [NIBBLE_W:0]   c;
  logic [NIBBLE_W-1:0] bx;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign bx[i]  = b[i] ^ sub;
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign c3 = c[NIBBLE_W-1];
  assign c4 = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// W-bit add/sub by reusing one 4-bit slice LSB nibble first; done NIBBLES+1 cycles after start.
// start is only honoured in IDLE or DONE; a start while busy is dropped, not queued.
module nibble_serial_addsub_ctrl
  import nibble_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  logic [1:0]                         state;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_reg;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_reg;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   res_reg;
  logic                               op_reg;
  logic                               carry_reg;
  logic [IW-1:0]                      idx;
  logic [NIBBLE_W-1:0]                s;
  logic                               c3;
  logic                               c4;

  addsub_nibble u_slice (
    .a   (a_reg[idx]),
    .b   (b_reg[idx]),
    .sub (op_reg),
    .cin (carry_reg),
    .s   (s),
    .c3  (c3),
    .c4  (c4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      op_reg    <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= op;
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            carry_reg <= op;
            idx       <= '0;
            state     <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          res_reg[idx] <= s;
          carry_reg    <= c4;
          if (idx == LAST) begin
            cout  <= c4;
            ovf   <= c3 ^ c4;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign result = res_reg;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Bench for nibble_serial_addsub_ctrl (NIBBLES=4) against an integer-arithmetic reference model.
module tb_nibble_serial_addsub_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  nibble_serial_addsub_ctrl #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: plain wide integer arithmetic, signed overflow from the true signed result.
  function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output logic v);
    longint ux, uy, sx, sy, sr;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 1'b0) begin
      r  = W'(ux + uy);
      c  = (ux + uy) >= (longint'(1) << W);
      sr = sx + sy;
    end else begin
      r  = W'(ux - uy);
      c  = ux >= uy;
      sr = sx - sy;
    end
    v = (sr >= (longint'(1) << (W - 1))) || (sr < -(longint'(1) << (W - 1)));
  endfunction

  // Drive one start pulse; operand inputs are scrambled afterwards to prove capture.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 1'($urandom);
  endtask

  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nbusy++;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result got=%h want=0", result); end
    n_cmp++; if ({cout, ovf} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b want=00", {cout, ovf}); end
  endtask

  typedef struct {
    logic         o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } case_t;

  task automatic test_directed();
    case_t tc[6];
    int    nb, c0;
    bit    seen;
    tc[0] = '{1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
    tc[1] = '{1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0};
    tc[2] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    tc[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    tc[4] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tc[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      c0 = cyc;
      issue(tc[k].o, tc[k].x, tc[k].y);
      wait_done(nb, seen);
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL dir%0d_timeout got=no_done want=done", k); end
      n_cmp++; if (nb != N) begin n_bad++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", k, nb, N); end
      n_cmp++; if (cyc - c0 != N + 1) begin n_bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, cyc - c0, N + 1); end
      n_cmp++; if (result !== tc[k].r) begin n_bad++; $display("FAIL dir%0d_result got=%h want=%h", k, result, tc[k].r); end
      n_cmp++; if (cout !== tc[k].c) begin n_bad++; $display("FAIL dir%0d_cout got=%b want=%b", k, cout, tc[k].c); end
      n_cmp++; if (ovf !== tc[k].v) begin n_bad++; $display("FAIL dir%0d_ovf got=%b want=%b", k, ovf, tc[k].v); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_after got=%b%b want=00", k, done, busy); end
      n_cmp++; if (result !== tc[k].r) begin n_bad++; $display("FAIL dir%0d_hold got=%h want=%h", k, result, tc[k].r); end
    end
  endtask

  task automatic test_back_to_back();
    int nb, c0;
    bit seen;
    c0 = cyc;
    issue(1'b0, 16'h1111, 16'h2222);
    // Hammer start with junk while running; none of it may be captured.
    for (int i = 0; i < N; i++) begin
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_c%0d got=%b want=1", i + 1, busy); end
      start = 1'b1; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
      tick();
    end
    n_cmp++; if (done !== 1'b1 || cyc - c0 != N + 1) begin n_bad++; $display("FAIL b2b_first_done got=%b@%0d want=1@%0d", done, cyc - c0, N + 1); end
    n_cmp++; if (result !== 16'h3333) begin n_bad++; $display("FAIL b2b_first_result got=%h want=3333", result); end
    // start held during the DONE cycle launches the next operation immediately.
    start = 1'b1; op = 1'b1; a = 16'h0100; b = 16'h0001;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_second_start got=%b%b want=10", busy, done); end
    wait_done(nb, seen);
    n_cmp++; if (!seen || nb != N || cyc - c0 != 2 * (N + 1)) begin n_bad++; $display("FAIL b2b_second_timing got=seen%0d busy%0d at%0d want=seen1 busy%0d at%0d", seen, nb, cyc - c0, N, 2 * (N + 1)); end
    n_cmp++; if (result !== 16'h00FF || cout !== 1'b1 || ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_second_result got=%h/%b/%b want=00ff/1/0", result, cout, ovf); end
    tick();
  endtask

  task automatic test_reset_mid();
    int nb;
    bit seen, saw_done;
    issue(1'b0, 16'h1234, 16'h4321);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({busy, done, cout, ovf} !== 4'b0000 || result !== '0) begin n_bad++; $display("FAIL rstmid_outputs got=%b%b%b%b/%h want=0000/0000", busy, done, cout, ovf, result); end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    n_cmp++; if (saw_done) begin n_bad++; $display("FAIL rstmid_no_done got=activity want=idle"); end
    issue(1'b0, 16'h00FF, 16'h0001);
    wait_done(nb, seen);
    n_cmp++; if (!seen || result !== 16'h0100 || cout !== 1'b0 || ovf !== 1'b0) begin n_bad++; $display("FAIL rstmid_after got=%0d/%h/%b/%b want=1/0100/0/0", seen, result, cout, ovf); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, er;
    logic         o, ec, ev;
    int           nb;
    bit           seen;
    for (int k = 0; k < 200; k++) begin
      o = 1'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      if (k % 8 == 0) y = 16'h8000;
      model(o, x, y, er, ec, ev);
      issue(o, x, y);
      wait_done(nb, seen);
      n_cmp++; if (!seen || nb != N) begin n_bad++; $display("FAIL rnd%0d_timing got=seen%0d busy%0d want=seen1 busy%0d", k, seen, nb, N); end
      n_cmp++; if (result !== er || cout !== ec || ovf !== ev) begin n_bad++; $display("FAIL rnd%0d_op%0d %h,%h got=%h/%b/%b want=%h/%b/%b", k, o, x, y, result, cout, ovf, er, ec, ev); end
      tick();
      n_cmp++; if (done !== 1'b0 || result !== er) begin n_bad++; $display("FAIL rnd%0d_pulse got=%b/%h want=0/%h", k, done, result, er); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
